// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like bus arbiter: one outstanding transaction, data-favoured
// arbitration with a bounded data streak so the instruction master cannot starve.
module sram_like_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic        inst_uncached,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic        data_uncached,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,

   output logic        bus_req,
   output logic        bus_wr,
   output logic        bus_uncached,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok
);

   localparam int unsigned StreakW =
      (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
   typedef enum logic {OwnData, OwnInst} owner_e;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [StreakW-1:0]  streak_q, streak_d;
   logic                owner_req;
   logic                fwd_addr_ok;
   logic                fwd_data_ok;
   logic                sel_inst;

   assign owner_req = (owner_q == OwnInst) ? inst_req : data_req;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      bus_req     = 1'b0;
      fwd_addr_ok = 1'b0;
      fwd_data_ok = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (inst_req || data_req) begin
               state_d = StAddr;
               if (inst_req && (!data_req || streak_q == StreakMax)) begin
                  owner_d  = OwnInst;
                  streak_d = '0;
               end else begin
                  owner_d = OwnData;
                  if (inst_req && streak_q != StreakMax) begin
                     streak_d = streak_q + StreakW'(1);
                  end
               end
            end
         end
         StAddr: begin
            bus_req = owner_req;
            if (!owner_req) begin
               // Master withdrew before addr_ok: drop the slot silently.
               state_d = StIdle;
            end else if (bus_addr_ok) begin
               fwd_addr_ok = 1'b1;
               if (bus_data_ok) begin
                  fwd_data_ok = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            fwd_data_ok = bus_data_ok;
            if (bus_data_ok) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Reset silences the bus and both masters within the reset cycle itself.
      if (rst) begin
         bus_req     = 1'b0;
         fwd_addr_ok = 1'b0;
         fwd_data_ok = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         owner_q  <= OwnData;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   assign sel_inst     = (state_q == StAddr) && (owner_q == OwnInst);
   assign bus_wr       = sel_inst ? inst_wr       : data_wr;
   assign bus_uncached = sel_inst ? inst_uncached : data_uncached;
   assign bus_size     = sel_inst ? inst_size     : data_size;
   assign bus_addr     = sel_inst ? inst_addr     : data_addr;
   assign bus_wdata    = sel_inst ? inst_wdata    : data_wdata;

   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;
   assign inst_addr_ok = fwd_addr_ok && (owner_q == OwnInst);
   assign inst_data_ok = fwd_data_ok && (owner_q == OwnInst);
   assign data_addr_ok = fwd_addr_ok && (owner_q == OwnData);
   assign data_data_ok = fwd_data_ok && (owner_q == OwnData);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: masters and slave are behavioural, a monitor checks
// responses against a per-master scoreboard and a protocol-level arbitration model.
module tb_sram_like_arbiter;

   localparam int MaxStreak = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_req [2];
   logic        m_wr  [2];
   logic        m_unc [2];
   logic [1:0]  m_size [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdata [2];
   logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata, bus_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        bus_req, bus_wr, bus_uncached, bus_addr_ok, bus_data_ok;
   logic [1:0]  bus_size;

   sram_like_arbiter #(.MAX_DATA_STREAK(MaxStreak)) dut (
      .clk(clk), .rst(rst),
      .inst_req(m_req[0]), .inst_wr(m_wr[0]), .inst_uncached(m_unc[0]),
      .inst_size(m_size[0]), .inst_addr(m_addr[0]), .inst_wdata(m_wdata[0]),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(m_req[1]), .data_wr(m_wr[1]), .data_uncached(m_unc[1]),
      .data_size(m_size[1]), .data_addr(m_addr[1]), .data_wdata(m_wdata[1]),
      .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_uncached(bus_uncached), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
   } exp_t;

   exp_t iq[$];
   exp_t dq[$];
   int   glog[$];
   int   total = 0;
   int   bad = 0;

   // Stimulus knobs and behavioural master/slave state.
   bit          m_wait [2];
   int          m_gap [2];
   int          m_left [2];
   int          gap_max, p_addr, p_same, p_spur, dmin, dmax;
   bit          fixed;
   bit          ok_a [2];
   bit          ok_d [2];
   bit          s_busy;
   int          s_cnt;
   logic [31:0] s_addr;
   int          cyc;
   int          issue_cyc [2];
   int          lat [2];
   bit          same_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h1234_5678;
   endfunction

   task automatic issue(input int m);
      exp_t e;
      m_req[m]  = 1'b1;
      m_unc[m]  = 1'($urandom_range(1, 0));
      m_size[m] = 2'($urandom_range(2, 0));
      if (fixed) begin
         m_addr[m] = (m == 0) ? 32'hBFC0_0000 : 32'h8000_1000;
         m_wr[m]   = (m == 1);
      end else begin
         m_addr[m] = $urandom & 32'hFFFF_FFFC;
         m_wr[m]   = 1'($urandom_range(1, 0));
      end
      m_wdata[m]   = $urandom;
      issue_cyc[m] = cyc;
      m_left[m]--;
      e.wr    = m_wr[m];
      e.rdata = slave_data(m_addr[m]);
      if (m == 0) iq.push_back(e);
      else        dq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int m = 0; m < 2; m++) begin
         if (ok_a[m]) begin
            m_req[m]  = 1'b0;
            m_wait[m] = 1'b1;
         end
         if (ok_d[m]) begin
            m_wait[m] = 1'b0;
            m_gap[m]  = $urandom_range(gap_max, 0);
         end
         if (!m_req[m] && !m_wait[m]) begin
            if (m_gap[m] != 0)      m_gap[m]--;
            else if (m_left[m] > 0) issue(m);
         end
      end
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (s_busy) begin
         if (s_cnt == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = slave_data(s_addr);
         end else begin
            s_cnt--;
         end
      end else if (bus_req && $urandom_range(99, 0) < p_addr) begin
         bus_addr_ok = 1'b1;
         if ($urandom_range(99, 0) < p_same) begin
            bus_data_ok = 1'b1;
            bus_rdata   = slave_data(bus_addr);
         end
      end else if ($urandom_range(99, 0) < p_spur) begin
         // Stray response with data that no pending request expects.
         bus_data_ok = 1'b1;
         bus_rdata   = slave_data(bus_addr) ^ 32'hA5A5_0000;
      end
      #1;
      ok_a[0] = inst_addr_ok;
      ok_d[0] = inst_data_ok;
      ok_a[1] = data_addr_ok;
      ok_d[1] = data_data_ok;
      for (int m = 0; m < 2; m++) if (ok_d[m]) lat[m] = cyc - issue_cyc[m];
      if (data_addr_ok && data_data_ok) same_seen = 1'b1;
      if (s_busy && bus_data_ok) begin
         s_busy = 1'b0;
      end else if (!s_busy && bus_req && bus_addr_ok && !bus_data_ok) begin
         s_busy = 1'b1;
         s_addr = bus_addr;
         s_cnt  = $urandom_range(dmax, dmin);
      end
   endtask

   function automatic bit all_idle();
      return m_left[0] == 0 && m_left[1] == 0 && !m_req[0] && !m_req[1] &&
             !m_wait[0] && !m_wait[1] && !s_busy;
   endfunction

   task automatic run_until_done(input int budget);
      int n = 0;
      while (!all_idle() && n < budget) begin
         step();
         n++;
      end
      chk("run_timeout", 32'(n >= budget), 32'd0);
   endtask

   task automatic clear_stim();
      for (int m = 0; m < 2; m++) begin
         m_req[m]  = 1'b0;
         m_wait[m] = 1'b0;
         m_left[m] = 0;
         m_gap[m]  = 0;
         ok_a[m]   = 1'b0;
         ok_d[m]   = 1'b0;
      end
      s_busy      = 1'b0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      iq.delete();
      dq.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_stim();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic set_slave(input int pa, input int ps, input int psp, input int dlo,
                            input int dhi);
      p_addr = pa;
      p_same = ps;
      p_spur = psp;
      dmin   = dlo;
      dmax   = dhi;
   endtask

   // Monitor: scoreboard pops plus a protocol-level arbitration model.
   int   mph = 0;
   int   mown = 0;
   int   mstreak = 0;
   logic [1:0] aok, dok;
   assign aok = {data_addr_ok, inst_addr_ok};
   assign dok = {data_data_ok, inst_data_ok};

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("reset_outputs", 32'({bus_req, aok, dok}), 32'd0);
         mph     = 0;
         mstreak = 0;
      end else begin
         if (inst_data_ok) begin
            if (iq.size() == 0) chk("inst_unexpected_data_ok", 32'd1, 32'd0);
            else begin
               e = iq.pop_front();
               if (!e.wr) chk("inst_rdata", inst_rdata, e.rdata);
            end
         end
         if (data_data_ok) begin
            if (dq.size() == 0) chk("data_unexpected_data_ok", 32'd1, 32'd0);
            else begin
               e = dq.pop_front();
               if (!e.wr) chk("data_rdata", data_rdata, e.rdata);
            end
         end
         case (mph)
            0: begin
               chk("idle_quiet", 32'({bus_req, aok, dok}), 32'd0);
               if (m_req[0] || m_req[1]) begin
                  if (m_req[0] && (!m_req[1] || mstreak == MaxStreak)) begin
                     mown    = 0;
                     mstreak = 0;
                  end else begin
                     mown = 1;
                     if (m_req[0] && mstreak < MaxStreak) mstreak++;
                  end
                  mph = 1;
               end
            end
            1: begin
               chk("addr_bus_req", 32'(bus_req), 32'd1);
               chk("addr_owner_addr_ok", 32'(aok[mown]), 32'(bus_addr_ok));
               chk("addr_owner_data_ok", 32'(dok[mown]), 32'(bus_addr_ok && bus_data_ok));
               chk("addr_other_ok", 32'({aok[1-mown], dok[1-mown]}), 32'd0);
               if (bus_addr_ok) begin
                  chk("bus_addr", bus_addr, m_addr[mown]);
                  chk("bus_ctl", 32'({bus_wr, bus_size, bus_uncached}),
                      32'({m_wr[mown], m_size[mown], m_unc[mown]}));
                  if (bus_wr) chk("bus_wdata", bus_wdata, m_wdata[mown]);
                  glog.push_back(mown);
                  mph = bus_data_ok ? 0 : 2;
               end
            end
            default: begin
               chk("data_bus_req", 32'(bus_req), 32'd0);
               chk("data_no_addr_ok", 32'(aok), 32'd0);
               chk("data_owner_data_ok", 32'(dok[mown]), 32'(bus_data_ok));
               chk("data_other_data_ok", 32'(dok[1-mown]), 32'd0);
               if (bus_data_ok) mph = 0;
            end
         endcase
      end
   end

   initial begin
      int exp_ord [10];
      exp_ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      for (int m = 0; m < 2; m++) begin
         m_wr[m]    = 1'b0;
         m_unc[m]   = 1'b0;
         m_size[m]  = 2'd0;
         m_addr[m]  = 32'd0;
         m_wdata[m] = 32'd0;
         lat[m]     = 0;
      end
      clear_stim();
      bus_rdata = 32'd0;
      cyc       = 0;
      fixed     = 1'b0;
      gap_max   = 3;
      same_seen = 1'b0;
      set_slave(60, 30, 15, 0, 3);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Random mixed traffic with stray responses.
      m_left[0] = 40;
      m_left[1] = 40;
      run_until_done(6000);

      // Single inst read: addr_ok next cycle, data_ok two cycles later.
      do_reset();
      fixed = 1'b1;
      set_slave(100, 0, 0, 1, 1);
      m_left[0] = 1;
      run_until_done(50);
      chk("inst_read_latency", 32'(lat[0]), 32'd3);

      // Both masters saturating: data streak capped at MaxStreak.
      do_reset();
      glog.delete();
      fixed   = 1'b0;
      gap_max = 0;
      set_slave(100, 100, 0, 0, 0);
      m_left[0] = 2;
      m_left[1] = 8;
      run_until_done(200);
      chk("grant_count", 32'(glog.size()), 32'd10);
      for (int i = 0; i < 10 && i < glog.size(); i++) chk("grant_order", 32'(glog[i]),
                                                          32'(exp_ord[i]));

      // Same-cycle addr_ok/data_ok on a data write.
      do_reset();
      fixed     = 1'b1;
      same_seen = 1'b0;
      m_left[1] = 1;
      run_until_done(50);
      chk("same_cycle_handshake", 32'(same_seen), 32'd1);

      // Reset while in DATA, then a late bus_data_ok that must not reach anyone.
      do_reset();
      set_slave(100, 0, 0, 5, 5);
      m_left[1] = 1;
      for (int n = 0; n < 20 && !s_busy; n++) step();
      chk("reached_data_phase", 32'(s_busy), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_stim();
      @(posedge clk);
      #1;
      rst         = 1'b0;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'hDEAD_BEEF;
      #2;
      chk("late_data_ok_blocked", 32'({inst_data_ok, data_data_ok, bus_req}), 32'd0);
      @(posedge clk);
      #1;
      bus_data_ok = 1'b0;
      repeat (4) step();

      // Stray bus_data_ok in IDLE leaves the arbiter untouched.
      do_reset();
      set_slave(0, 0, 100, 0, 0);
      repeat (5) step();
      set_slave(100, 0, 0, 1, 1);
      m_left[0] = 1;
      run_until_done(50);
      chk("inst_latency_after_stray", 32'(lat[0]), 32'd3);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: MAX_DATA_STREAK, default 4, max consecutive data grants while inst_req is pending before inst is forced.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inst_req, inst_wr, inst_uncached  in  1 each  instruction-master request, write flag, uncached attribute.
REQ-006 inst_size  in  2; inst_addr, inst_wdata  in  32 each  instruction-master request fields.
REQ-007 inst_rdata  out  32; inst_addr_ok, inst_data_ok  out  1 each  instruction-master responses.
REQ-008 data_req, data_wr, data_uncached  in  1; data_size  in  2; data_addr, data_wdata  in  32  data-master request.
REQ-009 data_rdata  out  32; data_addr_ok, data_data_ok  out  1  data-master responses.
REQ-010 bus_req, bus_wr, bus_uncached  out  1; bus_size  out  2; bus_addr, bus_wdata  out  32  shared sram-like request.
REQ-011 bus_rdata  in  32; bus_addr_ok, bus_data_ok  in  1  shared sram-like responses.

Function
REQ-012 The block SHALL serialize the two masters onto the bus with at most one outstanding transaction, using FSM states IDLE, ADDR, DATA and a registered owner (INST or DATA).
REQ-013 IDLE: bus_req=0. If data_req or inst_req is asserted, the block SHALL latch the owner and enter ADDR next cycle. Otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL favour data, except when inst_req=1 and streak==MAX_DATA_STREAK, in which case inst wins.
REQ-015 streak SHALL be 0..MAX_DATA_STREAK, saturating. It SHALL increment on a data grant with inst_req=1, clear on any inst grant, and hold on a data grant with inst_req=0.
REQ-016 ADDR: bus_req SHALL equal the owner's live req. bus_wr/size/addr/wdata/uncached SHALL pass through the owner's live inputs. owner_addr_ok SHALL equal bus_addr_ok.
REQ-017 ADDR with bus_addr_ok=1 and bus_data_ok=0: SHALL go to DATA.
REQ-018 ADDR with bus_addr_ok=1 and bus_data_ok=1 in the same cycle: SHALL forward both to the owner and go to IDLE.
REQ-019 ADDR with the owner's req dropped before addr_ok: SHALL return to IDLE with no handshake; this is a protocol violation and is tolerated.
REQ-020 DATA: bus_req=0. owner_data_ok SHALL equal bus_data_ok. On bus_data_ok=1 SHALL go to IDLE.
REQ-021 bus_rdata SHALL drive both inst_rdata and data_rdata combinationally. Only the owner's data_ok qualifies it.
REQ-022 The non-owner's addr_ok and data_ok SHALL be 0 in every state. Both masters' addr_ok and data_ok SHALL be 0 in IDLE.
REQ-023 bus_addr_ok or bus_data_ok arriving in IDLE, or bus_data_ok arriving in ADDR before addr_ok (other than REQ-018), SHALL be ignored and not forwarded.
REQ-024 Timing: request first seen at cycle T SHALL give bus_req at T+1. Minimum transaction length SHALL be 2 cycles (ADDR with same-cycle addr_ok and data_ok). One idle bubble SHALL separate back-to-back grants.
REQ-025 When not in ADDR, bus request fields SHALL be driven with the data master's inputs. Their values are don't-care when bus_req=0.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, owner=DATA, streak=0.
REQ-027 Outputs SHALL be 0 during and after reset until a grant: bus_req, all addr_ok and data_ok.
REQ-028 Reset mid-transaction SHALL abandon it without forwarding any later bus_data_ok.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Single inst read: inst_req=1, addr=0xBFC00000 at T; bus addr_ok at T+1, data_ok with rdata=0x3C1DBFC0 at T+3 -> bus_req=1 only at T+1; inst_addr_ok at T+1; inst_data_ok at T+3 with inst_rdata=0x3C1DBFC0; data_* responses 0 throughout.
REQ-031 Simultaneous requests: inst_req=data_req=1 at T, streak=0 -> data granted first; inst granted on the next IDLE; streak=1 then 0.
REQ-032 Starvation: both masters request continuously with MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-033 Same-cycle handshake: bus_addr_ok=bus_data_ok=1 in ADDR for a data write to 0x80001000 -> data_addr_ok=data_data_ok=1 that cycle; state IDLE next cycle.
REQ-034 Reset in DATA: rst=1 for one cycle, then bus_data_ok=1 -> no data_ok forwarded to either master; bus_req=0 until a new request.
REQ-035 Spurious response: bus_data_ok=1 in IDLE -> inst_data_ok=data_data_ok=0; state unchanged.
